// File: rtl/shift_seq_unit.sv
// Multi-cycle shift/rotate sequencer around a single logical shifter.
// SRA is completed in one pass using a sign mask; rotates merge two opposite-direction passes.
module shift_seq_unit #(
    parameter int DATA_WIDTH = 32,
    parameter bit ZERO_SKIP  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [2:0]            OP,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] S,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  ERR,
    output logic                  BUSY
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} stateT;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    stateT                 state;
    logic [2:0]            opLat;
    logic [DATA_WIDTH-1:0] dLat;
    logic [DATA_WIDTH-1:0] sLat;
    logic [DATA_WIDTH-1:0] tmp;
    logic [DATA_WIDTH-1:0] yReg;
    logic                  errReg;
    logic                  rspVld;
    logic                  reqRdy;
    logic                  busyReg;

    logic [DATA_WIDTH-1:0] shAmt;
    logic [DATA_WIDTH-1:0] shOut;
    logic [DATA_WIDTH-1:0] sraMask;
    logic                  shLeft;
    logic                  isRot;

    // Shift amounts of DATA_WIDTH or more yield zero, which the rotate merge relies on.
    function automatic logic [DATA_WIDTH-1:0] shiftPass(input logic [DATA_WIDTH-1:0] val,
                                                        input logic [DATA_WIDTH-1:0] amt,
                                                        input logic left);
        return left ? (val << amt) : (val >> amt);
    endfunction

    assign isRot   = (opLat == OP_ROL) || (opLat == OP_ROR);
    // Top min(S,32) bits set: all ones for S>=32, none for S==0.
    assign sraMask = dLat[DATA_WIDTH-1] ? ~({DATA_WIDTH{1'b1}} >> sLat) : '0;

    always_comb begin
        shAmt  = sLat;
        shLeft = 1'b0;
        if (state == PASS2) begin
            shAmt  = DATA_WIDTH'(6'd32 - {1'b0, sLat[4:0]});
            shLeft = (opLat == OP_ROR);
        end else begin
            shAmt  = isRot ? DATA_WIDTH'(sLat[4:0]) : sLat;
            shLeft = (opLat == OP_SLL) || (opLat == OP_ROL);
        end
        shOut = shiftPass(dLat, shAmt, shLeft);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            reqRdy  <= 1'b1;
            busyReg <= 1'b0;
            rspVld  <= 1'b0;
            yReg    <= '0;
            errReg  <= 1'b0;
            opLat   <= '0;
            dLat    <= '0;
            sLat    <= '0;
            tmp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        opLat   <= OP;
                        dLat    <= D;
                        sLat    <= S;
                        errReg  <= 1'b0;
                        reqRdy  <= 1'b0;
                        busyReg <= 1'b1;
                        state   <= PASS1;
                    end
                end
                PASS1: begin
                    tmp <= shOut;
                    if (isRot && !(ZERO_SKIP && sLat[4:0] == 5'd0)) begin
                        state <= PASS2;
                    end else begin
                        state  <= DONE;
                        rspVld <= 1'b1;
                        case (opLat)
                            OP_SLL, OP_SRL: yReg <= shOut;
                            OP_SRA:         yReg <= shOut | sraMask;
                            OP_ROL, OP_ROR: yReg <= dLat;
                            default: begin
                                yReg   <= '0;
                                errReg <= 1'b1;
                            end
                        endcase
                    end
                end
                PASS2: begin
                    yReg   <= tmp | shOut;
                    rspVld <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (RSP_READY) begin
                        rspVld  <= 1'b0;
                        busyReg <= 1'b0;
                        reqRdy  <= 1'b1;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign REQ_READY = reqRdy;
    assign RSP_VALID = rspVld;
    assign Y         = yReg;
    assign ERR       = errReg;
    assign BUSY      = busyReg;
endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: two instances (ZERO_SKIP 0 and 1) share stimulus and are
// compared against a bit-level reference model of the shift/rotate rules.
module tb_shift_seq_unit;
    logic        CLK = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        rspReady;
    logic [2:0]  op;
    logic [31:0] dIn;
    logic [31:0] sIn;
    logic        reqReady [2];
    logic        rspValid [2];
    logic        err      [2];
    logic        busy     [2];
    logic [31:0] yOut     [2];
    int          lat      [2];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 CLK = ~CLK;

    shift_seq_unit #(.DATA_WIDTH(32), .ZERO_SKIP(1'b0)) dut0 (
        .CLK(CLK), .RST(rst), .REQ_VALID(reqValid), .REQ_READY(reqReady[0]), .OP(op),
        .D(dIn), .S(sIn), .RSP_VALID(rspValid[0]), .RSP_READY(rspReady), .Y(yOut[0]),
        .ERR(err[0]), .BUSY(busy[0]));

    shift_seq_unit #(.DATA_WIDTH(32), .ZERO_SKIP(1'b1)) dut1 (
        .CLK(CLK), .RST(rst), .REQ_VALID(reqValid), .REQ_READY(reqReady[1]), .OP(op),
        .D(dIn), .S(sIn), .RSP_VALID(rspValid[1]), .RSP_READY(rspReady), .Y(yOut[1]),
        .ERR(err[1]), .BUSY(busy[1]));

    // Returns {err, y} built bit by bit from the operation definitions.
    function automatic logic [32:0] refModel(input logic [2:0] o, input logic [31:0] dd,
                                             input logic [31:0] ss);
        logic [31:0] r = '0;
        longint sh = longint'(ss);
        int rot = int'(ss % 32);
        case (o)
            3'd0: for (int i = 0; i < 32; i++) if (i + sh < 32) r[i + int'(sh)] = dd[i];
            3'd1: for (int i = 0; i < 32; i++) if (i >= sh) r[i - int'(sh)] = dd[i];
            3'd2: r = $signed(dd) >>> ((sh > 31) ? 31 : sh);
            3'd3: for (int i = 0; i < 32; i++) r[(i + rot) % 32] = dd[i];
            3'd4: for (int i = 0; i < 32; i++) r[(i + 32 - rot) % 32] = dd[i];
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    // Cycles from the accept cycle (0) to the first cycle with RSP_VALID high.
    function automatic int expLat(input logic [2:0] o, input logic [31:0] ss, input int skip);
        if (o == 3'd3 || o == 3'd4) return (skip == 1 && ss % 32 == 0) ? 2 : 3;
        return 2;
    endfunction

    function automatic logic [31:0] randS();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 31));
            1:       return 32'($urandom_range(32, 40));
            2:       return {$urandom_range(0, 7), 5'd0};
            default: return $urandom;
        endcase
    endfunction

    task automatic startTxn(input logic [2:0] o, input logic [31:0] dd, input logic [31:0] ss,
                            input bit holdReq);
        @(negedge CLK);
        op = o; dIn = dd; sIn = ss; reqValid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        if (!holdReq) reqValid = 1'b0;
    endtask

    task automatic waitRsp();
        int cyc = 1;
        lat[0] = -1; lat[1] = -1;
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < 2; k++) if (lat[k] < 0 && rspValid[k] === 1'b1) lat[k] = cyc;
            if (lat[0] >= 0 && lat[1] >= 0) break;
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic releaseRsp();
        rspReady = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rspReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; reqValid = 1'b0; rspReady = 1'b0; op = '0; dIn = '0; sIn = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({reqReady[k], rspValid[k], err[k], busy[k], yOut[k]} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
                miscompares++;
                $display("FAIL reset dut%0d: rdy/vld/err/busy/y=%b%b%b%b/%h expected 1000/00000000",
                         k, reqReady[k], rspValid[k], err[k], busy[k], yOut[k]);
            end
        end
    endtask

    task automatic test_logical();
        logic [2:0]  o;
        logic [31:0] dd, ss;
        logic [32:0] exp;
        for (int t = 0; t < 8; t++) begin
            o  = (t == 0) ? 3'd0 : 3'($urandom_range(0, 1));
            dd = (t == 0) ? 32'h0000_00F1 : $urandom;
            ss = (t == 0) ? 32'd4 : randS();
            exp = refModel(o, dd, ss);
            if (t == 0 && exp[31:0] !== 32'h0000_0F10) $display("FAIL model_sll got %h expected 00000f10", exp[31:0]);
            startTxn(o, dd, ss, 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (busy[k] !== 1'b1 || reqReady[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL logical_busy dut%0d: busy=%b rdy=%b expected 1 0", k, busy[k], reqReady[k]);
                end
            end
            waitRsp();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (yOut[k] !== exp[31:0] || err[k] !== exp[32]) begin
                    miscompares++;
                    $display("FAIL logical_y op%0d d=%h s=%h dut%0d: got %h/%b expected %h/%b",
                             o, dd, ss, k, yOut[k], err[k], exp[31:0], exp[32]);
                end
                vectors++;
                if (lat[k] != expLat(o, ss, k)) begin
                    miscompares++;
                    $display("FAIL logical_lat dut%0d: got %0d expected %0d", k, lat[k], expLat(o, ss, k));
                end
            end
            releaseRsp();
        end
    endtask

    task automatic test_sra();
        logic [31:0] tD [3] = '{32'h8000_0000, 32'h8000_0000, 32'h7000_0000};
        logic [31:0] tS [3] = '{32'd31, 32'd40, 32'd40};
        logic [31:0] tY [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] dd, ss, ey;
        for (int t = 0; t < 9; t++) begin
            dd = (t < 3) ? tD[t] : $urandom;
            ss = (t < 3) ? tS[t] : randS();
            ey = (t < 3) ? tY[t] : refModel(3'd2, dd, ss) >> 0;
            startTxn(3'd2, dd, ss, 1'b0);
            waitRsp();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (yOut[k] !== ey || err[k] !== 1'b0 || lat[k] != 2) begin
                    miscompares++;
                    $display("FAIL sra d=%h s=%h dut%0d: got %h err=%b lat=%0d expected %h 0 2",
                             dd, ss, k, yOut[k], err[k], lat[k], ey);
                end
            end
            releaseRsp();
        end
    endtask

    task automatic test_rotate();
        logic [2:0]  tO [3] = '{3'd3, 3'd4, 3'd3};
        logic [31:0] tS [3] = '{32'd1, 32'd33, 32'd32};
        logic [31:0] tY [3] = '{32'h0000_0003, 32'hC000_0000, 32'h8000_0001};
        logic [2:0]  o;
        logic [31:0] dd, ss, ey;
        for (int t = 0; t < 11; t++) begin
            o  = (t < 3) ? tO[t] : 3'($urandom_range(3, 4));
            dd = (t < 3) ? 32'h8000_0001 : $urandom;
            ss = (t < 3) ? tS[t] : randS();
            ey = (t < 3) ? tY[t] : 32'(refModel(o, dd, ss));
            startTxn(o, dd, ss, 1'b0);
            waitRsp();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (yOut[k] !== ey || err[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rotate op%0d d=%h s=%h dut%0d: got %h err=%b expected %h 0",
                             o, dd, ss, k, yOut[k], err[k], ey);
                end
                vectors++;
                if (lat[k] != expLat(o, ss, k)) begin
                    miscompares++;
                    $display("FAIL rotate_lat s=%h dut%0d: got %0d expected %0d", ss, k, lat[k], expLat(o, ss, k));
                end
            end
            releaseRsp();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ey = 32'hFF80_0012;
        startTxn(3'd2, 32'h8000_1234, 32'd8, 1'b1);
        waitRsp();
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (yOut[k] !== ey || err[k] !== 1'b0 || rspValid[k] !== 1'b1 || reqReady[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL backpressure_hold c%0d dut%0d: y=%h err=%b vld=%b rdy=%b expected %h 0 1 0",
                             c, k, yOut[k], err[k], rspValid[k], reqReady[k], ey);
                end
            end
        end
        rspReady = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rspReady = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (reqReady[k] !== 1'b1 || rspValid[k] !== 1'b0 || busy[k] !== 1'b0 || yOut[k] !== ey) begin
                miscompares++;
                $display("FAIL backpressure_idle dut%0d: rdy=%b vld=%b busy=%b y=%h expected 1 0 0 %h",
                         k, reqReady[k], rspValid[k], busy[k], yOut[k], ey);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        reqValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (busy[k] !== 1'b1 || reqReady[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_reaccept dut%0d: busy=%b rdy=%b expected 1 0", k, busy[k], reqReady[k]);
            end
        end
        waitRsp();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (yOut[k] !== ey || lat[k] != 2) begin
                miscompares++;
                $display("FAIL backpressure_second dut%0d: y=%h lat=%0d expected %h 2", k, yOut[k], lat[k], ey);
            end
        end
        releaseRsp();
    endtask

    task automatic test_reset_midop();
        startTxn(3'd3, 32'h8000_0001, 32'd5, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        rst = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (rspValid[k] !== 1'b0 || yOut[k] !== 32'h0 || reqReady[k] !== 1'b1 || busy[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_midop dut%0d: vld=%b y=%h rdy=%b busy=%b expected 0 00000000 1 0",
                         k, rspValid[k], yOut[k], reqReady[k], busy[k]);
            end
        end
        startTxn(3'd1, 32'hF000_0000, 32'd28, 1'b0);
        waitRsp();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (yOut[k] !== 32'h0000_000F || lat[k] != 2) begin
                miscompares++;
                $display("FAIL reset_srl dut%0d: y=%h lat=%0d expected 0000000f 2", k, yOut[k], lat[k]);
            end
        end
        releaseRsp();
    endtask

    task automatic test_illegal();
        startTxn(3'b110, 32'hFFFF_FFFF, 32'd3, 1'b0);
        waitRsp();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (yOut[k] !== 32'h0 || err[k] !== 1'b1 || lat[k] != 2) begin
                miscompares++;
                $display("FAIL illegal dut%0d: y=%h err=%b lat=%0d expected 00000000 1 2", k, yOut[k], err[k], lat[k]);
            end
        end
        releaseRsp();
        startTxn(3'd0, 32'h1, 32'd1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (err[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_clear dut%0d: err=%b expected 0", k, err[k]);
            end
        end
        waitRsp();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (yOut[k] !== 32'h2 || err[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_next dut%0d: y=%h err=%b expected 00000002 0", k, yOut[k], err[k]);
            end
        end
        releaseRsp();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] dd, ss;
        logic [32:0] exp;
        for (int t = 0; t < 30; t++) begin
            o = 3'($urandom_range(0, 7));
            dd = $urandom;
            ss = randS();
            exp = refModel(o, dd, ss);
            startTxn(o, dd, ss, 1'b0);
            waitRsp();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (yOut[k] !== exp[31:0] || err[k] !== exp[32] || lat[k] != expLat(o, ss, k)) begin
                    miscompares++;
                    $display("FAIL random op%0d d=%h s=%h dut%0d: got %h/%b lat=%0d expected %h/%b lat=%0d",
                             o, dd, ss, k, yOut[k], err[k], lat[k], exp[31:0], exp[32], expLat(o, ss, k));
                end
            end
            releaseRsp();
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_sra();
        test_rotate();
        test_backpressure();
        test_reset_midop();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
